// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Purpose:
//   Owns the architectural HI/LO register pair and the multi-cycle restoring
//   divider that feeds it. The write-back stage commits mthi/mtlo results
//   through the commit port. div/divu are issued here from execute, and the
//   pipeline stalls until the quotient and remainder are written into LO/HI.
//
// Configuration:
//   HILO_DIV_EN  defined   : divider, state machine and step counter built in.
//   HILO_DIV_EN  undefined : only the HI/LO registers and the commit path exist.
//                            The division inputs are accepted but ignored, and
//                            div_busy_o, div_done_o and stallreq_o are tied low.
//
// Parameters:
//   DIV_CYCLES    number of shift-subtract iterations (32 only)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   we_i          write-back HI/LO commit enable
//   hi_i, lo_i    values committed to HI/LO when we_i is high
//   div_start_i   division request from execute (level, held while stalled)
//   div_signed_i  1 = signed div, 0 = divu (sampled with start)
//   div_annul_i   abort the division in flight
//   dividend_i    rs operand (sampled with start)
//   divisor_i     rt operand (sampled with start)
//   hi_o, lo_o    current HI/LO register contents
//   div_busy_o    divider is not idle
//   div_done_o    high for the single cycle in which the result is written
//   stallreq_o    pipeline stall request
// -----------------------------------------------------------------------------
module hilo_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        div_start_i,
  input  logic        div_signed_i,
  input  logic        div_annul_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_busy_o,
  output logic        div_done_o,
  output logic        stallreq_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

`ifdef HILO_DIV_EN

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ON     = 2'd1,
    ST_BYZERO = 2'd2,
    ST_END    = 2'd3
  } divState_e;

  // Counter value seen during the final iteration cycle.
  localparam logic [5:0] LastStep = 6'(DIV_CYCLES - 1);

  divState_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] shift_q, shift_d;
  logic [31:0] divisor_q, divisor_d;
  logic        negQuot_q, negQuot_d;
  logic        negRem_q, negRem_d;

  logic        startOk;
  logic        dividendNeg, divisorNeg;
  logic [31:0] dividendMag, divisorMag;
  logic [32:0] partial, diff;
  logic        fits;
  logic [64:0] stepValue;
  logic [31:0] quotMag, remMag;
  logic [31:0] quotRes, remRes;
  logic        unusedRemTop;

  assign startOk = div_start_i & ~div_annul_i;

  // Operand preparation: the divider core only ever sees magnitudes. The sign
  // bits are reduced to two flags that say how to fix up the result at the end.
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
  // magnitude of -2^31, so no special case is needed for the most negative value.
  always_comb begin
    dividendNeg = div_signed_i & dividend_i[31];
    divisorNeg  = div_signed_i & divisor_i[31];
    dividendMag = dividendNeg ? (~dividend_i + 32'd1) : dividend_i;
    divisorMag  = divisorNeg  ? (~divisor_i  + 32'd1) : divisor_i;
  end

  // One restoring step. The shift register is {remainder[32:0], quotient[31:0]}.
  // The whole register shifts left by one. The shifted partial remainder is
  // compared against the divisor at 33 bits. If it fits, the partial remainder
  // is replaced by the difference and a 1 is shifted into the quotient.
  // Otherwise the partial remainder is restored and a 0 is shifted in.
  always_comb begin
    partial   = shift_q[63:31];
    fits      = (partial >= {1'b0, divisor_q});
    diff      = partial - {1'b0, divisor_q};
    stepValue = fits ? {diff,    shift_q[30:0], 1'b1}
                     : {partial, shift_q[30:0], 1'b0};
  end

  // The remainder is always below the divisor, so bit 64 never carries
  // information once a step completes.
  assign unusedRemTop = shift_q[64];

  // Result fix-up: negate the quotient when the operand signs differed.
  // The remainder follows the sign of the dividend.
  always_comb begin
    quotMag = shift_q[31:0];
    remMag  = shift_q[63:32];
    quotRes = negQuot_q ? (~quotMag + 32'd1) : quotMag;
    remRes  = negRem_q  ? (~remMag  + 32'd1) : remMag;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A request is taken only in IDLE, so a start held high
  // while stalled cannot restart the divider. Annul is honoured only while
  // iterating.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (startOk) begin
          state_d = (divisor_i == 32'd0) ? ST_BYZERO : ST_ON;
        end
      end
      ST_ON: begin
        if (div_annul_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LastStep) begin
          state_d = ST_END;
        end
      end
      ST_BYZERO: state_d = ST_END;
      ST_END:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode. The stall drops in END so that the div leaves execute in the
  // same cycle that HI/LO are written. The request in IDLE stalls
  // combinationally so the instruction never slips past the issue cycle.
  always_comb begin
    div_busy_o = (state_q != ST_IDLE);
    div_done_o = (state_q == ST_END);
    stallreq_o = ((state_q == ST_IDLE) & startOk)
               | (state_q == ST_ON)
               | (state_q == ST_BYZERO);
  end

  // Datapath next-state. The operands are captured only on the accepted start
  // cycle. Any later change on the operand inputs is therefore invisible.
  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    divisor_d = divisor_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    case (state_q)
      ST_IDLE: begin
        if (startOk) begin
          cnt_d     = 6'd0;
          shift_d   = {33'd0, dividendMag};
          divisor_d = divisorMag;
          negQuot_d = dividendNeg ^ divisorNeg;
          negRem_d  = dividendNeg;
        end
      end
      ST_ON: begin
        if (!div_annul_i) begin
          shift_d = stepValue;
          cnt_d   = cnt_q + 6'd1;
        end
      end
      ST_BYZERO: begin
        shift_d   = 65'd0;
        negQuot_d = 1'b0;
        negRem_d  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 6'd0;
      shift_q   <= 65'd0;
      divisor_q <= 32'd0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      divisor_q <= divisor_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
    end
  end

  // HI/LO next value. The divider result takes priority over a write-back
  // commit in the same cycle. The write-back instruction is older than the div,
  // so its value is architecturally dead once the div retires.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == ST_END) begin
      hi_d = remRes;
      lo_d = quotRes;
    end else if (we_i) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

`else

  // Divider compiled out: the division inputs are deliberately left unconnected
  // to any logic, and the status outputs never assert.
  localparam int unusedDivCycles = DIV_CYCLES;

  logic unusedDivInputs;
  assign unusedDivInputs = ^{div_start_i, div_signed_i, div_annul_i,
                             dividend_i, divisor_i};

  always_comb begin
    div_busy_o = 1'b0;
    div_done_o = 1'b0;
    stallreq_o = 1'b0;
  end

  // Commit path only.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we_i) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

`endif

  // Architectural HI/LO registers. The outputs come straight from these
  // registers. Any forwarding of newer values is done by the execute stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Scoreboard bench for hilo_unit. The driver pushes the expected HI/LO pair for
// every update it causes. The monitor pops that pair and compares it against
// hi_o/lo_o one cycle after it sees a commit or a div_done_o pulse.
// Division results come from a plain-arithmetic reference model.
// Compile with +define+HILO_DIV_EN to exercise the divider.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        div_start_i;
  logic        div_signed_i;
  logic        div_annul_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_busy_o;
  logic        div_done_o;
  logic        stallreq_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] curHi = 32'd0;
  logic [31:0] curLo = 32'd0;

  hilo_unit #(.DIV_CYCLES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .we_i         (we_i),
    .hi_i         (hi_i),
    .lo_i         (lo_i),
    .div_start_i  (div_start_i),
    .div_signed_i (div_signed_i),
    .div_annul_i  (div_annul_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .div_busy_o   (div_busy_o),
    .div_done_o   (div_done_o),
    .stallreq_o   (stallreq_o)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the division rules, using 64-bit signed arithmetic so
  // that -2^31 / -1 does not overflow. A zero divisor gives zero for both.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn,
                                 output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: one update is pending after a commit or done cycle, and it is
  // checked on the following negative edge. Reset discards any pending update.
  initial begin
    logic pending;
    exp_t e;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_underflow: got update expected none");
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_hi", hi_o, e.hi);
            checkOutput("sb_lo", lo_o, e.lo);
          end
        end
        pending = we_i || div_done_o;
      end
    end
  end

  // Write-back commit of a HI/LO pair.
  task automatic applyCommit(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    we_i = 1'b1;
    hi_i = h;
    lo_i = l;
    e.hi = h;
    e.lo = l;
    expQ.push_back(e);
    curHi = h;
    curLo = l;
    tick();
    we_i = 1'b0;
  endtask

`ifdef HILO_DIV_EN
  // Issue one division at the current cycle (cycle 0). Then follow it
  // cycle by cycle, checking the stall and busy signals and the done timing.
  // With annulAt > 0 the division is aborted in that ON cycle. With collide
  // set, a write-back commit is driven during END and must lose to the result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sgn, input int annulAt,
                               input bit collide);
    logic [31:0] q;
    logic [31:0] r;
    exp_t e;
    int   doneAt;
    int   doneSeen;
    int   expDone;
    div_start_i  = 1'b1;
    div_signed_i = sgn;
    div_annul_i  = 1'b0;
    dividend_i   = a;
    divisor_i    = b;
    #1;
    checkOutput("stall_cycle0", 32'(stallreq_o), 32'd1);
    refDiv(a, b, sgn, q, r);
    if (annulAt <= 0) begin
      e.hi = r;
      e.lo = q;
      expQ.push_back(e);
      curHi = r;
      curLo = q;
    end
    expDone = (b == 32'd0) ? 2 : 33;
    doneAt  = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        dividend_i   = $urandom;
        divisor_i    = $urandom;
        div_signed_i = 1'($urandom_range(0, 1));
      end
      if (annulAt > 0 && c == annulAt + 1) begin
        checkOutput("annul_busy", 32'(div_busy_o), 32'd0);
        checkOutput("annul_stall", 32'(stallreq_o), 32'd0);
        div_annul_i = 1'b0;
        break;
      end
      if (div_done_o) begin
        doneAt = c;
        checkOutput("stall_in_end", 32'(stallreq_o), 32'd0);
        div_start_i = 1'b0;
        if (collide) begin
          we_i = 1'b1;
          hi_i = 32'hDEAD;
          lo_i = 32'hDEAD;
        end
        tick();
        we_i = 1'b0;
        break;
      end
      checkOutput("stall_busy", {30'd0, stallreq_o, div_busy_o}, 32'd3);
      if (c == annulAt) begin
        div_annul_i = 1'b1;
        div_start_i = 1'b0;
      end
    end
    if (annulAt > 0) begin
      doneSeen = 0;
      for (int c = 0; c < 40; c++) begin
        if (div_done_o) doneSeen++;
        tick();
      end
      checkOutput("annul_no_done", 32'(doneSeen), 32'd0);
      checkOutput("annul_hi", hi_o, curHi);
      checkOutput("annul_lo", lo_o, curLo);
    end else begin
      checkOutput("done_cycle", 32'(doneAt), 32'(expDone));
    end
  endtask
`endif

  // Random divisor mix, weighted toward the boundary cases.
  function automatic logic [31:0] pickDivisor();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Main driver.
  initial begin
    rst          = 1'b0;
    we_i         = 1'b0;
    hi_i         = 32'd0;
    lo_i         = 32'd0;
    div_start_i  = 1'b0;
    div_signed_i = 1'b0;
    div_annul_i  = 1'b0;
    dividend_i   = 32'd0;
    divisor_i    = 32'd0;
    tick();
    tick();
    checkOutput("reset_hi", hi_o, 32'd0);
    checkOutput("reset_lo", lo_o, 32'd0);
    checkOutput("reset_flags", {29'd0, div_busy_o, div_done_o, stallreq_o}, 32'd0);
    rst = 1'b1;
    tick();

    applyCommit(32'h1234_5678, 32'h9ABC_DEF0);
    tick();

`ifdef HILO_DIV_EN
    applyStimulus(32'd100, 32'd7, 1'b0, 0, 1'b0);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
    applyStimulus(32'h55, 32'd0, 1'b0, 0, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);

    applyCommit(32'hA, 32'hB);
    applyStimulus(32'd1000, 32'd3, 1'b0, 10, 1'b0);

    applyStimulus(32'd9, 32'd4, 1'b0, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      applyStimulus(a, pickDivisor(), 1'($urandom_range(0, 1)), 0, 1'b0);
      if ($urandom_range(0, 1) == 1) applyCommit($urandom, $urandom);
    end

    // Reset in the middle of an iteration.
    div_start_i  = 1'b1;
    div_signed_i = 1'b0;
    dividend_i   = 32'd1000;
    divisor_i    = 32'd3;
    for (int c = 0; c < 20; c++) tick();
    div_start_i = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midreset_flags", {29'd0, div_busy_o, div_done_o, stallreq_o}, 32'd0);
    checkOutput("midreset_hi", hi_o, 32'd0);
    checkOutput("midreset_lo", lo_o, 32'd0);
    curHi = 32'd0;
    curLo = 32'd0;
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(32'd45, 32'd6, 1'b0, 0, 1'b0);
`else
    // Divider absent: requests must be ignored entirely.
    for (int i = 0; i < 6; i++) begin
      div_start_i  = 1'b1;
      div_signed_i = 1'($urandom_range(0, 1));
      dividend_i   = $urandom;
      divisor_i    = pickDivisor();
      for (int c = 0; c < 3; c++) begin
        #1;
        checkOutput("nodiv_flags", {29'd0, div_busy_o, div_done_o, stallreq_o}, 32'd0);
        tick();
      end
      div_start_i = 1'b0;
      checkOutput("nodiv_hi", hi_o, curHi);
      checkOutput("nodiv_lo", lo_o, curLo);
      applyCommit($urandom, $urandom);
    end
`endif

    for (int i = 0; i < 8; i++) begin
      applyCommit($urandom, $urandom);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Asynchronous reset in mid-cycle clears HI/LO immediately.
    applyCommit(32'hCAFE_F00D, 32'h0BAD_BEEF);
    tick();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_hi", hi_o, 32'd0);
    checkOutput("async_reset_lo", lo_o, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Owns the architectural HI/LO register pair and the multi-cycle divider that feeds it. It is the write/ownership end of the HI/LO path: the execute stage reads `hi_o`/`lo_o` and forwards newer values itself, the write-back stage commits `mthi`/`mtlo` results here, and `div`/`divu` are issued here from execute and stall the pipeline until the quotient and remainder are committed.

## Interface
Parameters:
- `DIV_CYCLES`, 32: number of iteration cycles. Fixed at 32 for a 32-bit restoring divider; no other value is supported.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `we_i`  in  1  write-back HI/LO commit enable
- `hi_i`  in  32  HI value to commit
- `lo_i`  in  32  LO value to commit
- `div_start_i`  in  1  execute requests a division; level, held while stalled
- `div_signed_i`  in  1  1 = `div`, 0 = `divu`; sampled with start
- `div_annul_i`  in  1  abort the division in flight
- `dividend_i`  in  32  rs operand; sampled with start
- `divisor_i`  in  32  rt operand; sampled with start
- `hi_o`  out  32  current HI register
- `lo_o`  out  32  current LO register
- `div_busy_o`  out  1  divider not IDLE
- `div_done_o`  out  1  high for the single END cycle
- `stallreq_o`  out  1  pipeline stall request

## Operation
- **Reset** (`rst`=0, async): HI=LO=0, state IDLE, counter 0, `div_busy_o`=`div_done_o`=`stallreq_o`=0.
- **Commit path:** when `we_i`=1, HI←`hi_i` and LO←`lo_i` on the next edge. There is no internal bypass; `hi_o`/`lo_o` are register outputs.
- **States:**
  - IDLE: if `div_start_i`=1 and `div_annul_i`=0, latch the operands. Go to BYZERO if `divisor_i`==0, else to ON.
  - ON: one restoring shift-subtract step per cycle for 32 cycles, then END. If `div_annul_i`=1, go to IDLE with no write.
  - BYZERO: result HI=0, LO=0; next state END.
  - END: `div_done_o`=1; on the exit edge, HI←remainder and LO←quotient; next state IDLE.
- **Signed division:** divide the magnitudes (two's-complement negate when the operand is negative and `div_signed_i`=1).
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Unsigned division:** operands are used as-is.
- **Internal width:** 65-bit shift register {remainder[32:0], quotient[31:0]}, with a 33-bit compare/subtract against the divisor.
- **Stall:** `stallreq_o` = (IDLE & `div_start_i` & ~`div_annul_i`) | ON | BYZERO. It is low in END, so the `div` leaves execute in the same cycle HI/LO are written.
- **Collision priority:** if `we_i`=1 during END, the divider result wins. The write-back instruction is older and is overwritten.
- `div_start_i` is ignored outside IDLE.
- Operand changes after the start cycle are ignored.

## Timing
- Cycle 0: start seen in IDLE; `stallreq_o`=1 combinationally.
- Cycles 1–32: ON; `div_busy_o`=1, `stallreq_o`=1.
- Cycle 33: END; `div_done_o`=1, `stallreq_o`=0.
- Cycle 34: new HI/LO visible on `hi_o`/`lo_o`.
- Divide by zero: cycle 1 BYZERO, cycle 2 END, visible cycle 3.
- Commit via `we_i` in cycle N is visible in cycle N+1.
- Annul in ON cycle k: back in IDLE at cycle k+1; HI/LO untouched; no done pulse.
- Reset asserted mid-division: immediate return to IDLE with zeroed outputs; no partial write.

## Configuration
- `HILO_DIV_EN` defined: divider, state machine and counter are compiled in as described.
- `HILO_DIV_EN` undefined:
  - Only the HI/LO registers and commit path remain.
  - Division ports stay present but are ignored.
  - `div_busy_o`, `div_done_o` and `stallreq_o` are tied to 0.

## Test plan
- **Reset/commit:** assert `rst`=0 mid-cycle → `hi_o`=`lo_o`=0 immediately. Then `we_i`=1, `hi_i`=0x12345678, `lo_i`=0x9ABCDEF0 → both visible next cycle.
- **Unsigned:** `divu` 100/7 → stall cycles 0–32, `div_done_o` at cycle 33, LO=14 and HI=2 at cycle 34.
- **Signed:** `div` 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 7 / −2 → LO=0xFFFFFFFD, HI=1.
- **Divide by zero:** 0x55 / 0 → END at cycle 2, HI=LO=0 at cycle 3.
- **Annul:** preload HI=0xA, LO=0xB; start 1000/3; `div_annul_i` at cycle 10 → IDLE at cycle 11, HI/LO stay 0xA/0xB, no `div_done_o`. Separately, `rst`=0 at cycle 20 → outputs zero, state IDLE.
- **Collision:** `we_i`=1 with HI=LO=0xDEAD during END of 9/4 → HI=1, LO=2 (divider wins).
